write_crossbar4x4: RTL

//   Write-side companion to the banked read crossbar. Routes up to four write requests

---
 rtl/write_crossbar4x4.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/write_crossbar4x4.sv
// write_crossbar4x4: routes four write requesters into four word-interleaved
// memory banks (bank = waddr[1:0]). Bank conflicts are arbitrated with a
// per-bank round-robin pointer; wready is combinational and the bank write
// strobes, addresses and data are registered (one-cycle latency).
// Optional feature macro: XBAR_STALL_CNT_EN adds a saturating 16-bit stall
// counter per requester port (stallcnt0..stallcnt3).
module write_crossbar4x4 #(
    parameter int ADDRW = 10,
    parameter int WL    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wvalid0,
    input  logic             wvalid1,
    input  logic             wvalid2,
    input  logic             wvalid3,
    input  logic [ADDRW-1:0] waddr0,
    input  logic [ADDRW-1:0] waddr1,
    input  logic [ADDRW-1:0] waddr2,
    input  logic [ADDRW-1:0] waddr3,
    input  logic [WL-1:0]    wdata0,
    input  logic [WL-1:0]    wdata1,
    input  logic [WL-1:0]    wdata2,
    input  logic [WL-1:0]    wdata3,
    output logic             wready0,
    output logic             wready1,
    output logic             wready2,
    output logic             wready3,
    output logic             bwe0,
    output logic             bwe1,
    output logic             bwe2,
    output logic             bwe3,
    output logic [ADDRW-3:0] baddr0,
    output logic [ADDRW-3:0] baddr1,
    output logic [ADDRW-3:0] baddr2,
    output logic [ADDRW-3:0] baddr3,
    output logic [WL-1:0]    bdata0,
    output logic [WL-1:0]    bdata1,
    output logic [WL-1:0]    bdata2,
    output logic [WL-1:0]    bdata3
`ifdef XBAR_STALL_CNT_EN
    ,
    output logic [15:0]      stallcnt0,
    output logic [15:0]      stallcnt1,
    output logic [15:0]      stallcnt2,
    output logic [15:0]      stallcnt3
`endif
);

    logic [3:0]       valid;
    logic [ADDRW-1:0] addr [4];
    logic [WL-1:0]    data [4];

    // req[b][p]: port p asks for bank b; gnt[b][p]: bank b grants port p
    logic [3:0][3:0]  req;
    logic [3:0][3:0]  gnt;
    logic [3:0][1:0]  gidx;
    logic [3:0]       bank_hit;
    logic [3:0]       ready;
    logic [1:0]       idx;

    logic [3:0][1:0]  ptr;
    logic [3:0]       bwe_q;
    logic [ADDRW-3:0] baddr_q [4];
    logic [WL-1:0]    bdata_q [4];

    assign valid   = {wvalid3, wvalid2, wvalid1, wvalid0};
    assign addr[0] = waddr0;
    assign addr[1] = waddr1;
    assign addr[2] = waddr2;
    assign addr[3] = waddr3;
    assign data[0] = wdata0;
    assign data[1] = wdata1;
    assign data[2] = wdata2;
    assign data[3] = wdata3;

    // Per-bank round-robin arbitration: scanning from ptr downwards in
    // reverse lets the requester closest to ptr overwrite later candidates.
    always_comb begin
        req      = '0;
        gnt      = '0;
        gidx     = '0;
        bank_hit = '0;
        ready    = '0;
        idx      = '0;
        for (int b = 0; b < 4; b++) begin
            for (int p = 0; p < 4; p++) begin
                req[b][p] = valid[p] && (addr[p][1:0] == 2'(b));
            end
            for (int k = 3; k >= 0; k--) begin
                idx = ptr[b] + 2'(k);
                if (req[b][idx]) begin
                    gnt[b]  = 4'b0001 << idx;
                    gidx[b] = idx;
                end
            end
            bank_hit[b] = |gnt[b];
            for (int p = 0; p < 4; p++) begin
                ready[p] = ready[p] | gnt[b][p];
            end
        end
        if (rst) begin
            ready = '0;
        end
    end

    assign wready0 = ready[0];
    assign wready1 = ready[1];
    assign wready2 = ready[2];
    assign wready3 = ready[3];

    // Register the winning write per bank and advance that bank's pointer past the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            bwe_q <= '0;
            for (int b = 0; b < 4; b++) begin
                baddr_q[b] <= '0;
                bdata_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                bwe_q[b] <= bank_hit[b];
                if (bank_hit[b]) begin
                    ptr[b]     <= gidx[b] + 2'd1;
                    baddr_q[b] <= addr[gidx[b]][ADDRW-1:2];
                    bdata_q[b] <= data[gidx[b]];
                end
            end
        end
    end

    assign bwe0   = bwe_q[0];
    assign bwe1   = bwe_q[1];
    assign bwe2   = bwe_q[2];
    assign bwe3   = bwe_q[3];
    assign baddr0 = baddr_q[0];
    assign baddr1 = baddr_q[1];
    assign baddr2 = baddr_q[2];
    assign baddr3 = baddr_q[3];
    assign bdata0 = bdata_q[0];
    assign bdata1 = bdata_q[1];
    assign bdata2 = bdata_q[2];
    assign bdata3 = bdata_q[3];

`ifdef XBAR_STALL_CNT_EN
    logic [3:0]  stall;
    logic [15:0] scnt [4];

    assign stall = valid & ~ready;

    // Count cycles each port waits on a conflict, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < 4; p++) begin
                scnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (stall[p] && (scnt[p] != 16'hFFFF)) begin
                    scnt[p] <= scnt[p] + 16'd1;
                end
            end
        end
    end

    assign stallcnt0 = scnt[0];
    assign stallcnt1 = scnt[1];
    assign stallcnt2 = scnt[2];
    assign stallcnt3 = scnt[3];
`endif

endmodule
